// File: rtl/b_sched_pkg.sv
// Shared state encoding, default sizing and pointer helper for the b_sched
// round-robin scheduler.
package b_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int LAT_DEF  = 2;

  // Successor of a requester index in a ring of n requesters.
  function automatic int rr_next(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/b_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping to 0, via a double-width masked priority encoder.
module rr_pick
  import b_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  logic [NREQ-1:0]   lo_s;
  logic [2*NREQ-1:0] dbl_s;

  // Low copy keeps only requesters at or above ptr; high copy supplies the wrap.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      lo_s[i] = req[i] & (i >= int'(ptr));
    end
    dbl_s = {req, lo_s};
    any   = |req;
    idx   = '0;
    for (int i = 2*NREQ-1; i >= 0; i--) begin
      idx = dbl_s[i] ? IDW'(i % NREQ) : idx;
    end
  end

endmodule

// File: rtl/b_sched.sv
// Round-robin scheduler sharing one b datapath unit among NREQ requesters,
// with a fixed-latency issue window and a valid/ready response channel.
module b_sched
  import b_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int LAT  = LAT_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_d1,
  input  logic [NREQ-1:0] req_d2,
  output logic [NREQ-1:0] gnt,
  output logic            b_in1,
  output logic            b_in2,
  input  logic            b_out1,
  input  logic            b_out2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IDW-1:0]  rsp_id,
  output logic            rsp_q1,
  output logic            rsp_q2,
  output logic            busy
);

  localparam int CW = $clog2(LAT + 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [IDW-1:0]  ptr_r;
  logic [IDW-1:0]  id_r;
  logic [NREQ-1:0] gnt_r;
  logic            b_in1_r;
  logic            b_in2_r;
  logic            rsp_valid_r;
  logic            rsp_q1_r;
  logic            rsp_q2_r;
  logic            busy_r;
  logic            pick_any_s;
  logic [IDW-1:0]  pick_idx_s;

  rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_pick (
    .req(req),
    .ptr(ptr_r),
    .any(pick_any_s),
    .idx(pick_idx_s)
  );

  // Scheduler FSM; b inputs carry the operands straight out of the grant edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cnt_r       <= '0;
      ptr_r       <= '0;
      id_r        <= '0;
      gnt_r       <= '0;
      b_in1_r     <= 1'b0;
      b_in2_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_q1_r    <= 1'b0;
      rsp_q2_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (pick_any_s) begin
            state_r <= S_ISSUE;
            busy_r  <= 1'b1;
            id_r    <= pick_idx_s;
            gnt_r   <= ONE_HOT0 << pick_idx_s;
            b_in1_r <= req_d1[pick_idx_s];
            b_in2_r <= req_d2[pick_idx_s];
          end else begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            gnt_r   <= '0;
          end
        end
        S_ISSUE: begin
          gnt_r <= '0;
          cnt_r <= CW'(LAT - 1);
          if (LAT == 1) begin
            state_r     <= S_RESP;
            rsp_valid_r <= 1'b1;
            rsp_q1_r    <= b_out1;
            rsp_q2_r    <= b_out2;
            b_in1_r     <= 1'b0;
            b_in2_r     <= 1'b0;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r     <= S_RESP;
            rsp_valid_r <= 1'b1;
            rsp_q1_r    <= b_out1;
            rsp_q2_r    <= b_out2;
            b_in1_r     <= 1'b0;
            b_in2_r     <= 1'b0;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_r     <= S_IDLE;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            ptr_r       <= IDW'(rr_next(int'(id_r), NREQ));
          end else begin
            state_r <= S_RESP;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          gnt_r       <= '0;
          b_in1_r     <= 1'b0;
          b_in2_r     <= 1'b0;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign b_in1     = b_in1_r;
  assign b_in2     = b_in2_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = id_r;
  assign rsp_q1    = rsp_q1_r;
  assign rsp_q2    = rsp_q2_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_b_sched.sv
// Bench for b_sched: a LAT=2 and a LAT=1 instance share stimulus; a
// transaction-level model is compared every cycle, plus directed literal checks.
module tb_b_sched;

  localparam int NREQ = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] req_d1 = 4'b0000;
  logic [3:0] req_d2 = 4'b0000;
  logic       rsp_ready = 1'b1;

  logic [3:0] gnt0, gnt1;
  logic       b_in1_0, b_in2_0, b_out1_0, b_out2_0;
  logic       b_in1_1, b_in2_1, b_out1_1, b_out2_1;
  logic       rsp_valid0, rsp_valid1, rsp_q1_0, rsp_q2_0, rsp_q1_1, rsp_q2_1;
  logic       busy0, busy1;
  logic [1:0] rsp_id0, rsp_id1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int g_idx[$];
  int g_cyc[$];
  int fair_ord[5] = '{0, 1, 2, 3, 0};

  bit m_busy[2];
  int m_age[2];
  int m_id[2];
  int m_ptr[2];
  bit m_d1[2], m_d2[2], m_q1[2], m_q2[2];

  always #5 clk = ~clk;

  // b stand-in: out1 = in1 xor in2, out2 = in1 or in2
  assign b_out1_0 = b_in1_0 ^ b_in2_0;
  assign b_out2_0 = b_in1_0 | b_in2_0;
  assign b_out1_1 = b_in1_1 ^ b_in2_1;
  assign b_out2_1 = b_in1_1 | b_in2_1;

  b_sched #(.NREQ(4), .LAT(2), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_d1(req_d1), .req_d2(req_d2),
    .gnt(gnt0), .b_in1(b_in1_0), .b_in2(b_in2_0), .b_out1(b_out1_0), .b_out2(b_out2_0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_id(rsp_id0),
    .rsp_q1(rsp_q1_0), .rsp_q2(rsp_q2_0), .busy(busy0)
  );

  b_sched #(.NREQ(4), .LAT(1), .IDW(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_d1(req_d1), .req_d2(req_d2),
    .gnt(gnt1), .b_in1(b_in1_1), .b_in2(b_in2_1), .b_out1(b_out1_1), .b_out2(b_out2_1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_id(rsp_id1),
    .rsp_q1(rsp_q1_1), .rsp_q2(rsp_q2_1), .busy(busy1)
  );

  function automatic int lat_of(input int u);
    return (u == 0) ? 2 : 1;
  endfunction

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction model: age counts edges since the grant edge.
  always @(posedge clk or negedge rst_n) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        m_busy[u] <= 1'b0;
        m_age[u]  <= 0;
        m_id[u]   <= 0;
        m_ptr[u]  <= 0;
      end else if (m_busy[u]) begin
        if (m_age[u] >= lat_of(u) && rsp_ready) begin
          m_busy[u] <= 1'b0;
          m_ptr[u]  <= (m_id[u] + 1) % NREQ;
        end else begin
          if (m_age[u] == lat_of(u) - 1) begin
            m_q1[u] <= m_d1[u] ^ m_d2[u];
            m_q2[u] <= m_d1[u] | m_d2[u];
          end
          m_age[u] <= m_age[u] + 1;
        end
      end else if (pick(req, m_ptr[u]) >= 0) begin
        m_busy[u] <= 1'b1;
        m_age[u]  <= 0;
        m_id[u]   <= pick(req, m_ptr[u]);
        m_d1[u]   <= req_d1[pick(req, m_ptr[u])];
        m_d2[u]   <= req_d2[pick(req, m_ptr[u])];
      end
    end
  end

  task automatic cmp(input int u, input int g, input int b1, input int b2, input int rv,
                     input int id, input int q1, input int q2, input int bz);
    bit live;
    bit resp;
    live = m_busy[u] && m_age[u] < lat_of(u);
    resp = m_busy[u] && m_age[u] >= lat_of(u);
    chk($sformatf("u%0d.gnt", u), g, (m_busy[u] && m_age[u] == 0) ? (1 << m_id[u]) : 0);
    chk($sformatf("u%0d.b_in1", u), b1, live ? int'(m_d1[u]) : 0);
    chk($sformatf("u%0d.b_in2", u), b2, live ? int'(m_d2[u]) : 0);
    chk($sformatf("u%0d.rsp_valid", u), rv, int'(resp));
    chk($sformatf("u%0d.busy", u), bz, int'(m_busy[u]));
    if (resp) begin
      chk($sformatf("u%0d.rsp_id", u), id, m_id[u]);
      chk($sformatf("u%0d.rsp_q1", u), q1, int'(m_q1[u]));
      chk($sformatf("u%0d.rsp_q2", u), q2, int'(m_q2[u]));
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      cmp(0, int'(gnt0), int'(b_in1_0), int'(b_in2_0), int'(rsp_valid0),
          int'(rsp_id0), int'(rsp_q1_0), int'(rsp_q2_0), int'(busy0));
      cmp(1, int'(gnt1), int'(b_in1_1), int'(b_in2_1), int'(rsp_valid1),
          int'(rsp_id1), int'(rsp_q1_1), int'(rsp_q2_1), int'(busy1));
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && gnt0 != 4'b0000) begin
      g_idx.push_back($clog2(gnt0));
      g_cyc.push_back(cyc);
    end
  end

  initial begin
    repeat (3) tick();
    chk("rst.gnt0", int'(gnt0), 0);
    chk("rst.b_in1_0", int'(b_in1_0), 0);
    chk("rst.rsp_valid0", int'(rsp_valid0), 0);
    chk("rst.busy0", int'(busy0), 0);
    chk("rst.busy1", int'(busy1), 0);
    rst_n = 1'b1;
    tick();

    // single request, requester 0, operands (1,0)
    req = 4'b0001; req_d1 = 4'b0001; req_d2 = 4'b0000;
    tick();
    chk("single.gnt", int'(gnt0), 1);
    chk("single.b_in1", int'(b_in1_0), 1);
    chk("single.b_in2", int'(b_in2_0), 0);
    chk("single.gnt_lat1", int'(gnt1), 1);
    req = 4'b0000;
    tick();
    chk("single.gnt_drop", int'(gnt0), 0);
    chk("single.b_in1_hold", int'(b_in1_0), 1);
    chk("single.no_rsp_yet", int'(rsp_valid0), 0);
    chk("single.rsp_lat1", int'(rsp_valid1), 1);
    tick();
    chk("single.rsp_valid", int'(rsp_valid0), 1);
    chk("single.rsp_id", int'(rsp_id0), 0);
    chk("single.rsp_q1", int'(rsp_q1_0), 1);
    chk("single.rsp_q2", int'(rsp_q2_0), 1);
    chk("single.b_in1_clr", int'(b_in1_0), 0);
    tick();
    chk("single.rsp_done", int'(rsp_valid0), 0);
    chk("single.idle", int'(busy0), 0);
    tick();

    // reset in WAIT with cnt=1
    req = 4'b0100; req_d1 = 4'b0100; req_d2 = 4'b0100;
    tick();
    chk("rstw.gnt", int'(gnt0), 4);
    req = 4'b0000;
    tick();
    chk("rstw.b_in1_wait", int'(b_in1_0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw.gnt0", int'(gnt0), 0);
    chk("rstw.b_in1", int'(b_in1_0), 0);
    chk("rstw.b_in2", int'(b_in2_0), 0);
    chk("rstw.busy0", int'(busy0), 0);
    chk("rstw.rsp_id0", int'(rsp_id0), 0);
    chk("rstw.rsp_valid0", int'(rsp_valid0), 0);
    chk("rstw.busy1", int'(busy1), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("rstw.no_rsp", int'(rsp_valid0), 0);
    end

    // fairness: all requesting, ready tied high
    g_idx.delete();
    g_cyc.delete();
    req = 4'b1111; req_d1 = 4'b0101; req_d2 = 4'b0011;
    repeat (18) tick();
    req = 4'b0000;
    repeat (6) tick();
    chk("fair.count", g_idx.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < g_idx.size()) chk($sformatf("fair.order%0d", k), g_idx[k], fair_ord[k]);
      if (k > 0 && k < g_idx.size()) chk($sformatf("fair.space%0d", k), g_cyc[k] - g_cyc[k-1], 4);
    end

    // back-pressure on requester 1 while others wait
    req = 4'b0010; req_d1 = 4'b0010; req_d2 = 4'b0000; rsp_ready = 1'b0;
    tick();
    chk("bp.gnt", int'(gnt0), 2);
    req = 4'b1101; req_d1 = 4'b0000; req_d2 = 4'b0000;
    repeat (2) tick();
    repeat (5) begin
      chk("bp.valid", int'(rsp_valid0), 1);
      chk("bp.id", int'(rsp_id0), 1);
      chk("bp.q1", int'(rsp_q1_0), 1);
      chk("bp.q2", int'(rsp_q2_0), 1);
      chk("bp.no_gnt", int'(gnt0), 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp.accepted", int'(rsp_valid0), 0);
    req = 4'b0000;
    repeat (2) tick();

    // bring ptr to 3 by serving requester 2, then wrap and skip
    req = 4'b0100; req_d1 = 4'b0000; req_d2 = 4'b0100;
    tick();
    chk("wrap.pre_gnt", int'(gnt0), 4);
    req = 4'b0000;
    repeat (4) tick();
    req = 4'b0101; req_d1 = 4'b0001; req_d2 = 4'b0100;
    tick();
    chk("wrap.gnt0", int'(gnt0), 1);
    req = 4'b0100;
    repeat (3) tick();
    tick();
    chk("wrap.gnt2", int'(gnt0), 4);
    req = 4'b0000;
    repeat (4) tick();

    // LAT=1 instance: ISSUE straight to RESP
    req = 4'b1000; req_d1 = 4'b1000; req_d2 = 4'b1000;
    tick();
    chk("lat1.gnt", int'(gnt1), 8);
    chk("lat1.b_in1", int'(b_in1_1), 1);
    chk("lat1.b_in2", int'(b_in2_1), 1);
    chk("lat1.no_rsp", int'(rsp_valid1), 0);
    req = 4'b0000;
    tick();
    chk("lat1.rsp_valid", int'(rsp_valid1), 1);
    chk("lat1.rsp_id", int'(rsp_id1), 3);
    chk("lat1.rsp_q1", int'(rsp_q1_1), 0);
    chk("lat1.rsp_q2", int'(rsp_q2_1), 1);
    chk("lat1.b_in1_clr", int'(b_in1_1), 0);
    tick();
    chk("lat1.done", int'(rsp_valid1), 0);
    chk("lat1.idle", int'(busy1), 0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
